// File: rtl/dma_mem_scheduler.sv
// dma_mem_scheduler: weighted round-robin owner of the single external memory port.
// Latency: request seen at edge N -> grant + mem_valid in cycle N+1 -> ch_ready one cycle after mem_ready.
// Backpressure: one transaction in flight; ch_req is ignored while busy and held transactions wait for mem_ready or timeout.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ch_req/we/addr/wdata  per-requester level request and its packed operands (32 bits per requester)
//   cfg_weight            per-requester consecutive-grant quota (0 behaves as 1)
//   ch_grant              one-cycle pulse: request consumed
//   ch_ready/ch_err       one-cycle completion pulse, err set when the response timed out
//   ch_rdata              read data (0 for writes, DEADBEEF on timeout), valid with ch_ready
//   mem_*                 memory request side, registered and stable while busy
//   busy                  high while a transaction owns the memory port
module dma_mem_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int WEIGHT_W    = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_we,
  input  logic [NUM_CH*32-1:0]         ch_addr,
  input  logic [NUM_CH*32-1:0]         ch_wdata,
  input  logic [NUM_CH*WEIGHT_W-1:0]   cfg_weight,
  output logic [NUM_CH-1:0]            ch_grant,
  output logic [NUM_CH-1:0]            ch_ready,
  output logic [NUM_CH-1:0]            ch_err,
  output logic [31:0]                  ch_rdata,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic                         mem_write_en,
  output logic                         mem_read_en,
  output logic                         mem_valid,
  input  logic [31:0]                  mem_rdata,
  input  logic                         mem_ready,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_last_owner;
  logic [WEIGHT_W-1:0]   r_credits;
  logic [NUM_CH-1:0]     r_owner_oh;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic                  r_we;
  logic [CNT_W-1:0]      r_tcnt;
  logic [NUM_CH-1:0]     r_grant;
  logic [NUM_CH-1:0]     r_ready;
  logic [NUM_CH-1:0]     r_err;
  logic [31:0]           r_rdata;

  logic                  w_any_req;
  logic                  w_sticky;
  logic                  w_found;
  int                    w_scan;
  logic [IDX_W-1:0]      w_win;
  logic [NUM_CH-1:0]     w_win_oh;
  logic [WEIGHT_W-1:0]   w_win_wt;
  logic [WEIGHT_W-1:0]   w_new_credits;
  logic                  w_timeout;

  assign w_any_req = |ch_req;
  assign w_timeout = (r_tcnt == CNT_LAST);

  // Arbitration: stay with the last owner while it still has quota, otherwise
  // scan cyclically starting just after the last owner.
  always_comb begin
    w_sticky = ch_req[r_last_owner] && (r_credits != '0);
    w_found  = 1'b0;
    w_win    = r_last_owner;
    w_scan   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_scan = (int'(r_last_owner) + i) % NUM_CH;
      if (!w_found && ch_req[w_scan[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_scan[IDX_W-1:0];
      end
    end
    if (w_sticky) begin
      w_win = r_last_owner;
    end
    w_win_oh      = NUM_CH'(1) << w_win;
    w_win_wt      = cfg_weight[w_win*WEIGHT_W +: WEIGHT_W];
    // A fresh winner gets eff_weight-1 further sticky grants; weight 0 acts as 1.
    w_new_credits = (w_win_wt == '0) ? '0 : (w_win_wt - WEIGHT_W'(1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_any_req) w_state_nxt = S_BUSY;
      S_BUSY: if (mem_ready || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: arbitration bookkeeping, holding registers, watchdog and response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= IDX_W'(NUM_CH - 1);
      r_credits    <= '0;
      r_owner_oh   <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_tcnt       <= '0;
      r_grant      <= '0;
      r_ready      <= '0;
      r_err        <= '0;
      r_rdata      <= '0;
    end else begin
      r_grant <= '0;
      r_ready <= '0;
      r_err   <= '0;
      r_rdata <= '0;
      if (r_state == S_IDLE) begin
        if (w_any_req) begin
          if (w_sticky) begin
            r_credits <= r_credits - WEIGHT_W'(1);
          end else begin
            r_credits    <= w_new_credits;
            r_last_owner <= w_win;
          end
          r_owner_oh <= w_win_oh;
          r_grant    <= w_win_oh;
          r_addr     <= ch_addr[w_win*32 +: 32];
          r_we       <= ch_we[w_win];
          // Reads present zero on mem_wdata, so clear the held data here.
          r_wdata    <= ch_we[w_win] ? ch_wdata[w_win*32 +: 32] : 32'h0;
          r_tcnt     <= '0;
        end
      end else begin
        if (mem_ready) begin
          r_ready <= r_owner_oh;
          r_rdata <= r_we ? 32'h0 : mem_rdata;
          r_tcnt  <= '0;
        end else if (w_timeout) begin
          r_ready <= r_owner_oh;
          r_err   <= r_owner_oh;
          r_rdata <= 32'hDEAD_BEEF;
          r_tcnt  <= '0;
        end else begin
          r_tcnt <= r_tcnt + CNT_W'(1);
        end
      end
    end
  end

  // Output logic: memory side is qualified by the state register so it drops
  // asynchronously with reset.
  always_comb begin
    busy         = (r_state == S_BUSY);
    mem_valid    = busy;
    mem_write_en = busy && r_we;
    mem_read_en  = busy && !r_we;
    mem_addr     = busy ? r_addr  : 32'h0;
    mem_wdata    = busy ? r_wdata : 32'h0;
    ch_grant     = r_grant;
    ch_ready     = r_ready;
    ch_err       = r_err;
    ch_rdata     = r_rdata;
  end

endmodule

// File: tb/tb_dma_mem_scheduler.sv
module tb_dma_mem_scheduler;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int T  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     ch_req;
  logic [N-1:0]     ch_we;
  logic [N*32-1:0]  ch_addr;
  logic [N*32-1:0]  ch_wdata;
  logic [N*WW-1:0]  cfg_weight;
  logic [N-1:0]     ch_grant;
  logic [N-1:0]     ch_ready;
  logic [N-1:0]     ch_err;
  logic [31:0]      ch_rdata;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_write_en;
  logic             mem_read_en;
  logic             mem_valid;
  logic [31:0]      mem_rdata;
  logic             mem_ready;
  logic             busy;

  always #5 clk = ~clk;

  dma_mem_scheduler #(.NUM_CH(N), .WEIGHT_W(WW), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .cfg_weight(cfg_weight),
    .ch_grant(ch_grant), .ch_ready(ch_ready), .ch_err(ch_err), .ch_rdata(ch_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference arbiter: owner keeps the port while its run of grants is below
  // the quota fixed when it was freshly chosen; otherwise next requester in ring order.
  int m_last, m_streak, m_quota;

  task automatic model_reset();
    m_last = N - 1; m_streak = 0; m_quota = 0;
  endtask

  task automatic pick(input logic [N-1:0] rv, input logic [N*WW-1:0] cfg, output int w);
    int wt;
    w = -1;
    if (rv[m_last] && m_streak < m_quota) begin
      m_streak++;
      w = m_last;
    end else begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_last + i) % N;
        if (w < 0 && rv[c]) w = c;
      end
      wt       = int'(cfg[w*WW +: WW]);
      m_last   = w;
      m_quota  = (wt == 0) ? 1 : wt;
      m_streak = 1;
    end
  endtask

  task automatic scramble();
    ch_req     = N'($urandom);
    ch_we      = N'($urandom);
    cfg_weight = (N*WW)'($urandom);
    for (int i = 0; i < N; i++) begin
      ch_addr[i*32 +: 32]  = $urandom;
      ch_wdata[i*32 +: 32] = $urandom;
    end
  endtask

  // One arbitration round, entered at a negedge while idle. k = BUSY cycle in
  // which mem_ready is raised (k > T means never). we_sel < 0 randomises ch_we.
  task automatic txn(input logic [N-1:0] rv, input logic [N*WW-1:0] cfg,
                     input int k, input int we_sel, output int w);
    logic [31:0]  a [N];
    logic [31:0]  d [N];
    logic [N-1:0] we;
    logic [31:0]  rd;
    logic [31:0]  one;
    bit           done, tmo;
    int           c;
    one = 32'h1;
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom; d[i] = $urandom;
      ch_addr[i*32 +: 32]  = a[i];
      ch_wdata[i*32 +: 32] = d[i];
    end
    we = (we_sel < 0) ? N'($urandom) : (we_sel != 0 ? '1 : '0);
    ch_we = we; ch_req = rv; cfg_weight = cfg; mem_ready = 1'b0;
    if (rv == '0) begin
      w = -1;
      @(posedge clk); @(negedge clk);
      chk("idle_grant", 32'(ch_grant), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      return;
    end
    pick(rv, cfg, w);
    @(posedge clk); @(negedge clk);
    chk("grant", 32'(ch_grant), one << w);
    chk("ready_during_grant", 32'(ch_ready), 32'h0);
    chk("mem_valid", 32'(mem_valid), 32'h1);
    chk("mem_addr", mem_addr, a[w]);
    chk("mem_wdata", mem_wdata, we[w] ? d[w] : 32'h0);
    chk("mem_write_en", 32'(mem_write_en), 32'(we[w]));
    chk("mem_read_en", 32'(mem_read_en), 32'(!we[w]));
    done = 1'b0; tmo = 1'b0; c = 1; rd = 32'h0;
    while (!done) begin
      if (c > 1) begin
        chk("hold_valid", 32'(mem_valid), 32'h1);
        chk("hold_addr", mem_addr, a[w]);
        chk("grant_pulse", 32'(ch_grant), 32'h0);
      end
      scramble();
      rd = $urandom;
      mem_rdata = rd;
      mem_ready = (c == k);
      @(posedge clk); @(negedge clk);
      if (c == k) done = 1'b1;
      else if (c == T) begin done = 1'b1; tmo = 1'b1; end
      c++;
    end
    mem_ready = 1'b0;
    chk("ch_ready", 32'(ch_ready), one << w);
    chk("ch_err", 32'(ch_err), tmo ? (one << w) : 32'h0);
    chk("ch_rdata", ch_rdata, tmo ? 32'hDEADBEEF : (we[w] ? 32'h0 : rd));
    chk("valid_drop", 32'(mem_valid), 32'h0);
    chk("busy_drop", 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    ch_req = '0; mem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_order(input string tag, input logic [N-1:0] rv,
                           input logic [N*WW-1:0] cfg, input int exp_seq [10], input int cnt);
    int w;
    for (int i = 0; i < cnt; i++) begin
      txn(rv, cfg, 1, -1, w);
      chk(tag, 32'(w), 32'(exp_seq[i]));
    end
  endtask

  initial begin
    int w;
    int seq_eq  [10];
    int seq_wt  [10];
    int seq_w0  [10];
    logic [N*WW-1:0] cfg;
    seq_eq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    seq_wt = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    seq_w0 = '{0, 0, 1, 1, 2, 0, 0, 1, 1, 2};

    rst_n = 1'b0; ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    cfg_weight = '0; mem_rdata = '0; mem_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(mem_valid), 32'h0);
    chk("rst_grant", 32'(ch_grant), 32'h0);
    chk("rst_ready", 32'(ch_ready), 32'h0);
    chk("rst_err", 32'(ch_err), 32'h0);
    chk("rst_rdata", ch_rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    rst_n = 1'b1;

    // Single read from ch0, four BUSY cycles.
    txn(4'b0001, 16'h1111, 4, 0, w);
    chk("single_owner", 32'(w), 32'h0);

    do_reset();
    run_order("equal_order", 4'b1111, 16'h1111, seq_eq, 10);
    do_reset();
    run_order("weighted_order", 4'b0011, 16'h0013, seq_wt, 10);
    do_reset();
    run_order("weight0_order", 4'b0111, 16'h2022, seq_w0, 10);

    // Timeout on a write from ch1, then a normal transaction.
    txn(4'b0010, 16'h1111, T + 1, 1, w);
    txn(4'b0010, 16'h1111, 2, -1, w);
    chk("after_timeout_owner", 32'(w), 32'h1);
    // mem_ready on the last allowed cycle wins over the timeout.
    txn(4'b0001, 16'h1111, T, -1, w);

    // mem_ready while idle is ignored.
    ch_req = '0; mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("idle_mem_ready_busy", 32'(busy), 32'h0);
    chk("idle_mem_ready_rdy", 32'(ch_ready), 32'h0);
    mem_ready = 1'b0;

    // Reset in the middle of a transaction.
    ch_req = 4'b0100;
    @(posedge clk); @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(mem_valid), 32'h0);
    chk("async_grant", 32'(ch_grant), 32'h0);
    chk("async_ready", 32'(ch_ready), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    ch_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    txn(4'b1111, 16'h1111, 2, -1, w);
    chk("post_reset_owner", 32'(w), 32'h0);

    // Randomised traffic against the reference arbiter.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++) cfg[i*WW +: WW] = WW'($urandom_range(0, 3));
      txn(N'($urandom_range(0, 15)), cfg, $urandom_range(1, T + 1), -1, w);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dma_mem_scheduler.md
Name: dma_mem_scheduler

Overview:
- Weighted round-robin scheduler that shares the single external memory port among NUM_CH DMA requesters (channels, descriptor fetcher, etc.).
- Captures one word transaction per grant and drives the memory port until the response arrives.
- Returns read data and completion to the owning requester.
- Supervises every transaction with a response-timeout watchdog and reports bus errors per requester.

Parameters:
- NUM_CH, 4, number of requesters (2..8).
- WEIGHT_W, 4, width of each per-requester weight field.
- TIMEOUT_CYC, 256, maximum BUSY cycles waiting for mem_ready before abort (must be ≥ 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ch_req  in  NUM_CH  per-requester transaction request, level
- ch_we  in  NUM_CH  1 = write, 0 = read
- ch_addr  in  NUM_CH*32  packed word addresses, requester i at bits [32i+31:32i]
- ch_wdata  in  NUM_CH*32  packed write data
- cfg_weight  in  NUM_CH*WEIGHT_W  consecutive-transaction quota per requester
- ch_grant  out  NUM_CH  one-hot, one-cycle pulse: request consumed
- ch_ready  out  NUM_CH  one-hot, one-cycle pulse: transaction complete
- ch_err  out  NUM_CH  one-cycle pulse with ch_ready: transaction timed out
- ch_rdata  out  32  read data, valid with ch_ready
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_write_en  out  1  write strobe
- mem_read_en  out  1  read strobe
- mem_valid  out  1  request valid
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory response/completion
- busy  out  1  high while in BUSY

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; last_owner=NUM_CH-1; credits=0; timeout counter=0.
- States are IDLE and BUSY.
- IDLE, no ch_req bit set: stay IDLE.
- IDLE, any ch_req bit set: select winner w at the clock edge.
  - Sticky case: if ch_req[last_owner] and credits>0, w=last_owner and credits decrements by 1.
  - Otherwise: w = first requester set, searching cyclically from last_owner+1. Set credits = eff_weight(w)-1, where eff_weight = max(cfg_weight[w],1). Set last_owner=w.
  - Register ch_addr[w], ch_wdata[w], ch_we[w] into internal holding registers. ch_grant[w] pulses for exactly the next cycle. Go to BUSY.
- BUSY:
  - mem_valid=1; mem_addr and mem_wdata come from the holding registers (mem_wdata is 0 for reads).
  - mem_write_en = held we; mem_read_en = !held we.
  - Outputs are registered and stable for the whole BUSY period.
  - Timeout counter increments each BUSY cycle.
- BUSY with mem_ready=1 at an edge: go to IDLE. Next cycle: ch_ready[w]=1; ch_rdata = captured mem_rdata for reads, 0 for writes. mem_valid drops the same cycle ch_ready rises. Counter clears.
- BUSY with counter==TIMEOUT_CYC-1 and mem_ready=0: abort and go to IDLE. Next cycle: ch_ready[w]=1, ch_err[w]=1, ch_rdata=32'hDEADBEEF.
- mem_ready and timeout on the same edge: mem_ready wins, no error.
- Minimum transaction latency: req seen at edge N; grant and mem_valid during cycle N+1; ready at N+1 → ch_ready during cycle N+2. Back-to-back arbitration is possible in that same cycle N+2 (IDLE lasts one cycle).
- Request consumption:
  - A request is consumed at grant.
  - A requester keeping ch_req high after its grant issues a new transaction using its then-current addr/wdata.
  - ch_req is ignored while in BUSY.
- ch_addr, ch_wdata, ch_we, and cfg_weight may change freely while BUSY with no effect on the held transaction.
- A requester that drops ch_req before grant is simply not selected; there is no penalty.
- Fairness:
  - No requester is granted more than eff_weight consecutive transactions while another is requesting.
  - A sole requester is granted indefinitely; credits reload on each fresh selection.
- mem_ready while IDLE is ignored.
- Reset mid-BUSY: mem_valid drops asynchronously; no ch_ready is issued for the lost transaction.

Test Plan:
- Single read: ch_req[0] with addr 0x100, memory returns 0xA5A5_0001 after 3 cycles → ch_grant[0] on the cycle after req; mem_addr=0x100, mem_read_en=1 for 4 BUSY cycles; ch_ready[0] with ch_rdata=0xA5A5_0001; ch_err=0.
- Equal weights, contention: all weights 1, ch_req=4'b1111 held, mem_ready 1 cycle → grant order 0,1,2,3,0,1… (starting from reset last_owner=3).
- Weighted: weights ch0=3, ch1=1, both requesting continuously → grant pattern 0,0,0,1,0,0,0,1.
- Weight 0: cfg_weight ch2=0 → ch2 is treated as weight 1 and never starves.
- Timeout: TIMEOUT_CYC=8, write from ch1, mem_ready never asserted → mem_valid high exactly 8 cycles; then ch_ready[1]=ch_err[1]=1 with ch_rdata=0xDEADBEEF; the next request is served normally.
- Reset mid-transaction: rst_n low during BUSY → mem_valid, ch_grant, ch_ready immediately 0; after release the first grant goes to ch0 when all request.
- Simultaneous mem_ready and timeout: mem_ready on the final allowed cycle → completion with ch_err=0.
